// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard receive path.
// Frame is start(0), 8 data bits LSB first, odd parity, stop(1).
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_scan_fifo.sv
// First-word-fall-through FIFO: o_dat shows the head while o_vld, count updates 1 cycle after push/pop.
// No backpressure on push: a push into a full FIFO without a pop is dropped and flagged on o_ovf.
module ps2_scan_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_vld,
  output logic [CW-1:0]    o_count,
  output logic             o_ovf
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = i_push & (~w_full | w_pop);

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
    end
  end

  assign o_dat   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_vld   = ~w_empty;
  assign o_count = r_count;
  assign o_ovf   = i_push & w_full & ~w_pop;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: pin sync, clock glitch filter, frame FSM with watchdog, scan-code FIFO.
// Good byte visible on rd_data 1 cycle after the stop-bit fall strobe; full FIFO drops bytes and sets overflow.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ps2_clk,
  input  logic                             ps2_data,
  input  logic                             rd_en,
  output logic [PS2_DATA_BITS-1:0]         rd_data,
  output logic                             rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  input  logic                             err_clr,
  output logic                             parity_err,
  output logic                             frame_err,
  output logic                             timeout_err,
  output logic                             overflow
);

  localparam int FCW = $clog2(FILTER_LEN);
  localparam int WW  = $clog2(TIMEOUT_CYCLES + 1);

  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic r_clk_filt;
  logic [FCW-1:0] r_filt_cnt;
  logic r_fall;

  ps2_rx_state_t            r_state, w_state_nxt;
  logic [2:0]               r_bit_cnt, w_bit_cnt_nxt;
  logic [PS2_DATA_BITS-1:0] r_byte, w_byte_nxt;
  logic                     r_par, w_par_nxt;
  logic [WW-1:0]            r_wdog;

  logic w_timeout, w_push, w_frame_ev, w_par_ev, w_ovf_ev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
        r_fall     <= ~r_clk_s2;
      end else begin
        r_filt_cnt <= r_filt_cnt + FCW'(1);
      end
    end
  end

  assign w_timeout = (r_state != IDLE) && !r_fall && (r_wdog == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_byte    <= '0;
      r_par     <= 1'b0;
      r_wdog    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_byte    <= w_byte_nxt;
      r_par     <= w_par_nxt;
      if (r_fall || w_timeout || r_state == IDLE) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + WW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_byte_nxt    = r_byte;
    w_par_nxt     = r_par;
    w_push        = 1'b0;
    w_frame_ev    = 1'b0;
    w_par_ev      = 1'b0;
    if (w_timeout) begin
      w_state_nxt   = IDLE;
      w_bit_cnt_nxt = '0;
      w_byte_nxt    = '0;
    end else if (r_fall) begin
      case (r_state)
        IDLE: begin
          if (r_dat_s2) begin
            w_frame_ev = 1'b1;
          end else begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          w_byte_nxt[r_bit_cnt] = r_dat_s2;
          w_bit_cnt_nxt         = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
            w_state_nxt = PARITY;
          end
        end
        PARITY: begin
          w_par_nxt   = r_dat_s2;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (!r_dat_s2) begin
            w_frame_ev = 1'b1;
          end else if (!odd_parity_ok(r_byte, r_par)) begin
            w_par_ev = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  ps2_scan_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (r_byte),
    .i_pop      (rd_en),
    .o_dat      (rd_data),
    .o_vld      (rd_valid),
    .o_count    (fifo_count),
    .o_ovf      (w_ovf_ev)
  );

  // A new event outranks err_clr in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      parity_err  <= w_par_ev   | (parity_err  & ~err_clr);
      frame_err   <= w_frame_ev | (frame_err   & ~err_clr);
      timeout_err <= w_timeout  | (timeout_err & ~err_clr);
      overflow    <= w_ovf_ev   | (overflow    & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: senders queue expected bytes, a monitor checks every pop.
// PS/2 bit timing is scaled down to keep the run short.
module tb_ps2_kbd_rx;
  import ps2_pkg::*;

  localparam int FL   = 8;
  localparam int FD   = 16;
  localparam int TO   = 300;
  localparam int HALF = 30;
  localparam int CW   = $clog2(FD + 1);

  logic clock = 1'b0;
  logic reset, ps2_clk, ps2_data, rd_en, err_clr;
  logic [7:0] rd_data;
  logic rd_valid;
  logic [CW-1:0] fifo_count;
  logic parity_err, frame_err, timeout_err, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  ps2_kbd_rx #(
    .FILTER_LEN     (FL),
    .FIFO_DEPTH     (FD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_count  (fifo_count),
    .err_clr     (err_clr),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .overflow    (overflow)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [PS2_FRAME_BITS-1:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                                           input logic stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [PS2_FRAME_BITS-1:0] f, input int nbits, input logic glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch) begin
        cyc(15);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(HALF - 18);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input logic glitch, input logic expect_push);
    send_bits(mk_frame(b, bad_par, stop), PS2_FRAME_BITS, glitch);
    ps2_data = 1'b1;
    cyc(HALF);
    if (expect_push) exp_q.push_back(b);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  function automatic logic [31:0] errs();
    return {28'd0, parity_err, frame_err, timeout_err, overflow};
  endfunction

  always @(negedge clock) begin
    if (!reset && rd_en && rd_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got %0h want none", rd_data);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_bad++;
          $display("FAIL pop_data: got %0h want %0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0; reset = 1'b1;
    cyc(3);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_errs", errs(), 0);
    reset = 1'b0;
    cyc(5);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t1_valid", 32'(rd_valid), 1);
    chk("t1_count", 32'(fifo_count), 1);
    chk("t1_errs", errs(), 0);
    pop();
    chk("t1_valid_after_pop", 32'(rd_valid), 0);
    chk("t1_count_after_pop", 32'(fifo_count), 0);

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_count", 32'(fifo_count), 0);
    chk("t2_errs_parity", errs(), 32'b1000);
    clr_err();
    chk("t2_errs_cleared", errs(), 0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2_count_f0", 32'(fifo_count), 1);
    pop();

    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t3_count", 32'(fifo_count), 1);
    chk("t3_errs", errs(), 0);
    pop();
    chk("t3_valid_after_pop", 32'(rd_valid), 0);

    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 1'b0, i <= FD);
    end
    chk("t4_count_full", 32'(fifo_count), FD);
    chk("t4_errs_overflow", errs(), 32'b0001);
    for (int i = 0; i < FD; i++) pop();
    chk("t4_valid_drained", 32'(rd_valid), 0);
    chk("t4_count_drained", 32'(fifo_count), 0);
    clr_err();

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_errs_stop", errs(), 32'b0100);
    chk("t5_count", 32'(fifo_count), 0);
    clr_err();
    send_bits(11'h7FF, 1, 1'b0);
    cyc(HALF);
    chk("t5_errs_start", errs(), 32'b0100);
    clr_err();

    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 5, 1'b0);
    cyc(TO - HALF - 5);
    chk("t6_no_timeout_yet", 32'(timeout_err), 0);
    cyc(35);
    chk("t6_timeout", 32'(timeout_err), 1);
    chk("t6_count", 32'(fifo_count), 0);
    clr_err();
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_count_29", 32'(fifo_count), 1);
    chk("t6_errs", errs(), 0);
    pop();

    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t7_count_3", 32'(fifo_count), 3);
    send_bits(mk_frame(8'h76, 1'b0, 1'b1), 5, 1'b0);
    ps2_data = 1'b1;
    reset = 1'b1;
    cyc(2);
    exp_q.delete();
    chk("t7_rst_valid", 32'(rd_valid), 0);
    chk("t7_rst_data", 32'(rd_data), 0);
    chk("t7_rst_count", 32'(fifo_count), 0);
    chk("t7_rst_errs", errs(), 0);
    reset = 1'b0;
    cyc(5);
    send_frame(8'h76, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t7_count_76", 32'(fifo_count), 1);
    chk("t7_errs", errs(), 0);
    pop();
    chk("t7_valid_after_pop", 32'(rd_valid), 0);

    cyc(2);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 device-to-host receiver that feeds the AXI_PS2_Keyboard register block. It does four things:
- synchronises and glitch-filters the raw ps2_clk/ps2_data pins;
- deserialises 11-bit PS/2 frames and checks start, odd parity and stop bits;
- runs a frame watchdog;
- buffers good scan-code bytes in a first-word-fall-through FIFO.

The AXI slave pops bytes and reads the sticky error/status bits.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples needed before the filtered ps2_clk changes state (>=2)
FIFO_DEPTH, 16, scan-code FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 100000, clock cycles allowed between consecutive filtered ps2_clk falling edges inside a frame (1 ms at 100 MHz)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
rd_en  in  1  pop request; ignored when rd_valid=0
rd_data  out  8  head-of-FIFO scan code (FWFT)
rd_valid  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy
err_clr  in  1  clears all sticky error bits
parity_err  out  1  sticky: frame rejected for bad parity
frame_err  out  1  sticky: start bit=1 after edge, or stop bit=0
timeout_err  out  1  sticky: watchdog expired mid-frame
overflow  out  1  sticky: good byte dropped because FIFO full

Behaviour:
- Reset: all outputs 0, rd_data=8'h00, FSM=IDLE, FIFO empty, filtered clk=1, filter counter=0, watchdog=0. Reset mid-frame discards the partial frame.
- Sync: 2-FF synchroniser on each pin.
- Clock filter:
  - filtered ps2_clk toggles only after FILTER_LEN consecutive cycles of the synchronised level differing from the current filtered value;
  - the counter clears whenever the sample equals the filtered value.
- Sampling: a falling edge of filtered clk (1->0) produces a one-cycle fall strobe; the synchronised ps2_data is sampled on that cycle. ps2_data is not filtered.
- FSM states IDLE, DATA, PARITY, STOP; bits LSB first:
  - IDLE: on fall, if data=0 -> DATA with bit_cnt=0; if data=1 -> set frame_err, stay IDLE.
  - DATA: on fall, shift data into byte[bit_cnt]; after the 8th bit -> PARITY.
  - PARITY: on fall, capture parity bit -> STOP.
  - STOP: on fall, check stop bit and parity, then return to IDLE:
    - stop=0 -> frame_err, no push;
    - else if XOR(byte, parity) != 1 -> parity_err, no push;
    - else push the byte.
- Watchdog: counts cycles in any non-IDLE state, cleared on every fall strobe. When it reaches TIMEOUT_CYCLES: set timeout_err, return to IDLE, discard the partial byte.
- Latency: a good byte is written on the clock edge ending the STOP fall-strobe cycle. rd_valid/rd_data/fifo_count reflect it on the next cycle, i.e. 1 cycle after the strobe.
- FIFO (FWFT):
  - rd_data is always the oldest entry while rd_valid=1; the pop takes effect at the clock edge with rd_en & rd_valid.
  - Push with count==FIFO_DEPTH and no pop: byte dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle: both take effect (legal when full); count unchanged.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky errors: err_clr clears all four. If an error event and err_clr coincide, the event wins and the bit stays 1.
- Error events never alter FIFO contents.

Decomposition:
- Package ps2_pkg:
  - typedef enum ps2_rx_state_t {IDLE, DATA, PARITY, STOP};
  - localparams PS2_DATA_BITS=8 and PS2_FRAME_BITS=11;
  - function odd_parity_ok(byte, p).
- Sub-module ps2_scan_fifo: parameterised FWFT synchronous FIFO with data, count and overflow-on-push-when-full. The top holds sync, filter, FSM and watchdog.

Test Plan:
- Send frame 0x1C (start 0, data LSB first, parity 0, stop 1) at a 60 us PS/2 period -> rd_valid=1, rd_data=8'h1C, fifo_count=1, all errors 0; pulse rd_en -> rd_valid=0, count=0.
- Send 0x1C with parity bit 1 -> no push, fifo_count=0, parity_err=1; err_clr pulse -> parity_err=0; a following good 0xF0 frame -> rd_data=8'hF0.
- Inject 3-cycle low glitches on ps2_clk between bit edges of a 0x5A frame (FILTER_LEN=8) -> exactly one byte 8'h5A received, no errors.
- Push 17 good frames 0x01..0x11 with no pops -> fifo_count=16, overflow=1; 16 pops return 0x01..0x10 in order, then rd_valid=0.
- Send start + 4 data bits, then hold ps2_clk high -> timeout_err=1 exactly TIMEOUT_CYCLES after the last fall, FSM back to IDLE; next full frame 0x29 received correctly.
- Assert reset mid-frame after 5 bits with 3 bytes queued -> all outputs 0, FIFO empty; after release, frame 0x76 received as the sole entry.
